uart_io: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the 6502-style CPU bus of the VIC64 system.
- Occupies two byte addresses at BASE_ADDR:
  - data register: write = transmit, read = receive
  - status register
- Contains an independent transmitter (tx_p) and receiver (rx_p).
- The receiver has a single-byte holding register.

---
 rtl/uart_io_if.sv | 13 +
 rtl/uart_io.sv | 167 ++++++++++++++++
 tb/tb_uart_io.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_io_if.sv
// CPU-side bus of the uart_io peripheral: 6502-style address/data with a chip
// select, an access strobe and a read/write line.
interface uart_io_if;
  logic [15:0] a;
  logic        select;
  logic        bus_access_strobe;
  logic        r_w_n;
  logic [7:0]  d_in;
  logic [7:0]  d_out;

  modport master (output a, select, bus_access_strobe, r_w_n, d_in, input d_out);
  modport slave  (input a, select, bus_access_strobe, r_w_n, d_in, output d_out);
endinterface

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART: data register at BASE_ADDR, status at BASE_ADDR+1,
// independent transmitter and receiver with a single-byte receive holding register.
module uart_io #(
  parameter logic [15:0] BASE_ADDR    = 16'hDF00,
  parameter int          CLKS_PER_BIT = 208
) (
  input  logic      clk,
  input  logic      reset,
  uart_io_if.slave  bus,
  output logic      tx_p,
  input  logic      rx_p
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           tx_state, tx_state_n, rx_state, rx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0]       tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic             tx_n;
  logic             rx_sync_p0, rx_sync_p1, rx_prev_p2;
  logic             rx_ok, rx_bad;
  logic [7:0]       rx_data;
  logic             receiver_full, overrun, framing_err;
  logic             tx_busy;
  logic             data_sel, stat_sel, wr_data, rd_data, rd_stat;
  logic [7:0]       status;

  assign data_sel = bus.select && (bus.a == BASE_ADDR);
  assign stat_sel = bus.select && (bus.a == BASE_ADDR + 16'd1);
  assign wr_data  = data_sel && !bus.r_w_n && bus.bus_access_strobe;
  assign rd_data  = data_sel && bus.r_w_n && bus.bus_access_strobe;
  assign rd_stat  = stat_sel && bus.r_w_n && bus.bus_access_strobe;
  assign tx_busy  = (tx_state != S_IDLE);
  assign status   = {3'b000, ~tx_busy, receiver_full, overrun, framing_err, 1'b0};

  // Transmitter: each state lasts one bit period; tx_p only moves at bit boundaries.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CNT_W'(1);
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_n       = tx_p;
    unique case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (wr_data) begin
          tx_sh_n    = bus.d_in;
          tx_state_n = S_START;
          tx_n       = 1'b0;
        end
      end
      S_START: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_bit_n   = 3'd0;
        tx_state_n = S_DATA;
        tx_n       = tx_sh[0];
      end
      S_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_state_n = S_STOP;
          tx_n       = 1'b1;
        end else begin
          tx_bit_n = tx_bit + 3'd1;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          tx_n     = tx_sh[1];
        end
      end
      S_STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_state_n = S_IDLE;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // Receiver: start validated at half a bit, then one sample per bit period.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CNT_W'(1);
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_ok      = 1'b0;
    rx_bad     = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev_p2 && !rx_sync_p1) rx_state_n = S_START;
      end
      S_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n   = '0;
        rx_bit_n   = 3'd0;
        rx_state_n = rx_sync_p1 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_sync_p1, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      S_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_state_n = S_IDLE;
        rx_ok      = rx_sync_p1;
        rx_bad     = !rx_sync_p1;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    tx_sh  <= tx_sh_n;
    tx_bit <= tx_bit_n;
    rx_sh  <= rx_sh_n;
    rx_bit <= rx_bit_n;
    if (reset) begin
      tx_state   <= S_IDLE;
      rx_state   <= S_IDLE;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tx_p       <= 1'b1;
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      tx_state   <= tx_state_n;
      rx_state   <= rx_state_n;
      tx_cnt     <= tx_cnt_n;
      rx_cnt     <= rx_cnt_n;
      tx_p       <= tx_n;
      rx_sync_p0 <= rx_p;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  // Register file; a completing byte outranks a same-cycle clearing read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.d_out     <= 8'h00;
      rx_data       <= 8'h00;
      receiver_full <= 1'b0;
      overrun       <= 1'b0;
      framing_err   <= 1'b0;
    end else begin
      if (data_sel && bus.r_w_n)      bus.d_out <= rx_data;
      else if (stat_sel && bus.r_w_n) bus.d_out <= status;
      if (rd_data) begin
        receiver_full <= 1'b0;
        overrun       <= 1'b0;
      end
      if (rx_ok) begin
        rx_data       <= rx_sh;
        receiver_full <= 1'b1;
        if (receiver_full && !rd_data) overrun <= 1'b1;
      end
      if (rd_stat) framing_err <= 1'b0;
      if (rx_bad)  framing_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io: loopback transfers, bit timing, busy flag,
// write-while-busy, overrun, reset mid-frame and framing error.
module tb_uart_io;
  localparam logic [15:0] DATA_A = 16'hDF00;
  localparam logic [15:0] STAT_A = 16'hDF01;
  localparam int          CPB    = 208;

  logic clk = 1'b0;
  logic reset;
  logic tx_line, rx_line;
  logic loop_en, rx_drv;
  int   total = 0;
  int   bad   = 0;

  uart_io_if bus_if ();

  uart_io #(.BASE_ADDR(16'hDF00), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx_p  (tx_line),
    .rx_p  (rx_line)
  );

  assign rx_line = loop_en ? tx_line : rx_drv;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.select            = 1'b0;
    bus_if.bus_access_strobe = 1'b0;
    bus_if.r_w_n             = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.a = addr; bus_if.d_in = data; bus_if.select = 1'b1;
    bus_if.r_w_n = 1'b0; bus_if.bus_access_strobe = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic stb, output logic [7:0] v);
    @(negedge clk);
    bus_if.a = addr; bus_if.select = 1'b1;
    bus_if.r_w_n = 1'b1; bus_if.bus_access_strobe = stb;
    @(negedge clk);
    v = bus_if.d_out;
    bus_idle();
  endtask

  task automatic poll(input int bitn, input string tag);
    logic [7:0] v;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      bus_read(STAT_A, 1'b0, v);
      if (v[bitn]) found = 1'b1;
    end
    check(tag, {7'd0, found}, 8'h01);
  endtask

  task automatic send_level(input logic lvl);
    rx_drv = lvl;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [9:0] frame;
    logic [7:0] fe_byte;

    loop_en = 1'b1; rx_drv = 1'b1; reset = 1'b1;
    bus_if.a = 16'h0000; bus_if.d_in = 8'h00;
    bus_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_dout", bus_if.d_out, 8'h00);
    check("reset_tx", {7'd0, tx_line}, 8'h01);
    bus_read(STAT_A, 1'b0, v);   check("reset_status", v, 8'h10);
    bus_read(16'hDF02, 1'b1, v); check("other_addr_hold", v, 8'h10);
    bus_read(DATA_A, 1'b0, v);   check("reset_rxdata", v, 8'h00);

    // 0xAA: bit timing of the whole frame, then loopback receive
    frame = {1'b1, 8'hAA, 1'b0};
    bus_write(DATA_A, 8'hAA);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("aa_bit%0d_first", k), {7'd0, tx_line}, {7'd0, frame[k]});
      repeat (CPB - 1) @(negedge clk);
      check($sformatf("aa_bit%0d_last", k), {7'd0, tx_line}, {7'd0, frame[k]});
      @(negedge clk);
    end
    poll(4, "aa_tx_idle");
    poll(3, "aa_rx_full");
    bus_read(DATA_A, 1'b1, v); check("aa_data", v, 8'hAA);
    bus_read(DATA_A, 1'b1, v); check("aa_data_repeat", v, 8'hAA);
    bus_read(STAT_A, 1'b0, v); check("aa_status_after", v, 8'h10);

    // 0x55: busy flag visible next cycle, idle exactly one frame after the write edge
    bus_write(DATA_A, 8'h55);
    bus_if.a = STAT_A; bus_if.select = 1'b1; bus_if.r_w_n = 1'b1;
    @(negedge clk);
    check("busy_next_cycle", {7'd0, bus_if.d_out[4]}, 8'h00);
    repeat (10 * CPB - 1) @(negedge clk);
    check("busy_at_2080", {7'd0, bus_if.d_out[4]}, 8'h00);
    @(negedge clk);
    check("idle_at_2081", {7'd0, bus_if.d_out[4]}, 8'h01);
    bus_idle();
    poll(3, "55_rx_full");
    bus_read(DATA_A, 1'b1, v); check("55_data", v, 8'h55);

    // 0xFF
    bus_write(DATA_A, 8'hFF);
    poll(4, "ff_tx_idle");
    poll(3, "ff_rx_full");
    bus_read(DATA_A, 1'b1, v); check("ff_data", v, 8'hFF);

    // second write while busy must be dropped
    bus_write(DATA_A, 8'h12);
    repeat (10) @(negedge clk);
    bus_write(DATA_A, 8'h34);
    poll(4, "wb_tx_idle");
    poll(3, "wb_rx_full");
    bus_read(DATA_A, 1'b1, v); check("wb_data", v, 8'h12);
    repeat (300) @(negedge clk);
    bus_read(STAT_A, 1'b0, v); check("wb_no_second", v, 8'h10);

    // overrun: two bytes without reading
    bus_write(DATA_A, 8'h11);
    poll(4, "ov_tx1_idle");
    bus_write(DATA_A, 8'h22);
    poll(4, "ov_tx2_idle");
    repeat (20) @(negedge clk);
    bus_read(STAT_A, 1'b1, v); check("ov_status", v, 8'h1C);
    bus_read(DATA_A, 1'b1, v); check("ov_data", v, 8'h22);
    bus_read(STAT_A, 1'b0, v); check("ov_status_clr", v, 8'h10);

    // reset during data bit 3 (0x52 has bit3 = 0)
    bus_write(DATA_A, 8'h52);
    repeat (900) @(negedge clk);
    check("mid_tx_low", {7'd0, tx_line}, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_tx_high", {7'd0, tx_line}, 8'h01);
    repeat (2500) @(negedge clk);
    bus_read(STAT_A, 1'b0, v); check("rst_status", v, 8'h10);
    bus_read(DATA_A, 1'b0, v); check("rst_rxdata", v, 8'h00);

    // framing error: hand-driven frame with a low stop bit
    loop_en = 1'b0;
    fe_byte = 8'hA5;
    repeat (5) @(negedge clk);
    send_level(1'b0);
    for (int k = 0; k < 8; k++) send_level(fe_byte[k]);
    send_level(1'b0);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    bus_read(STAT_A, 1'b0, v); check("fe_status", v, 8'h12);
    bus_read(STAT_A, 1'b1, v); check("fe_status_stb", v, 8'h12);
    bus_read(STAT_A, 1'b0, v); check("fe_cleared", v, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
